// File: rtl/fb_arb_pkg.sv
// Shared types and widths for the frame-buffer read-port arbiter.
// Used by the arbiter top and by its tag pipe.
package fb_arb_pkg;

  localparam int FB_ADDR_W = 21;
  localparam int FB_DATA_W = 8;

  typedef enum logic [1:0] {ARB_RUN, ARB_DRAIN, ARB_HALT} arb_state_t;

  typedef enum logic {OWN_VGA, OWN_BLT} owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

endpackage

// File: rtl/fb_tag_pipe.sv
// Shift register of {valid, owner} tags that follows every issued read
// through the fixed port latency so returned data can be steered.
module fb_tag_pipe
  import fb_arb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_valid,
  input  owner_t push_owner,
  output logic   out_valid,
  output owner_t out_owner,
  output logic   empty
);

  logic [DEPTH-1:0] valid_vec;
  tag_t             tail_tag;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : stage
      tag_t stage_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_reg <= '{valid: 1'b0, owner: OWN_VGA};
        end else if (gi == 0) begin
          stage_reg <= '{valid: push_valid, owner: push_owner};
        end else begin
          stage_reg <= stage[(gi > 0) ? gi - 1 : 0].stage_reg;
        end
      end

      assign valid_vec[gi] = stage_reg.valid;
    end
  endgenerate

  assign tail_tag  = stage[DEPTH-1].stage_reg;
  assign out_valid = tail_tag.valid;
  assign out_owner = tail_tag.owner;

  // High when nothing will still be in flight after this cycle: the tail
  // stage may be delivering now, but no earlier stage and no new push holds a read.
  assign empty = !push_valid && !(|valid_vec[DEPTH-2:0]);

endmodule

// File: rtl/fb_read_arbiter.sv
// Two-requester arbiter for the single frame-buffer read port: VGA prefetch
// has priority, the tile/sprite composer gets a forced win after STARVE_MAX losses.
module fb_read_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              drained,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              blt_req,
  input  logic [ADDR_W-1:0] blt_addr,
  output logic              blt_gnt,
  output logic              blt_rvalid,
  output logic [DATA_W-1:0] blt_rdata,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd,
  input  logic [DATA_W-1:0] fb_rdata,
  output logic [3:0]        starve_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t state;
  logic       grant_ok;
  logic       blt_wins;
  logic       any_gnt;
  owner_t     push_owner;
  logic       tag_valid;
  owner_t     tag_owner;
  logic       pipe_empty;

  // enable is looked at directly so a request in the cycle enable falls is refused.
  assign grant_ok   = rst_n && (state == ARB_RUN) && enable;
  assign blt_wins   = blt_req && (!vga_req || (starve_cnt == STARVE_LIM));
  assign vga_gnt    = grant_ok && vga_req && !blt_wins;
  assign blt_gnt    = grant_ok && blt_wins;
  assign any_gnt    = vga_gnt || blt_gnt;
  assign push_owner = blt_gnt ? OWN_BLT : OWN_VGA;

  fb_tag_pipe #(
    .DEPTH(RD_LAT + 1)
  ) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (any_gnt),
    .push_owner (push_owner),
    .out_valid  (tag_valid),
    .out_owner  (tag_owner),
    .empty      (pipe_empty)
  );

  assign vga_rvalid = tag_valid && (tag_owner == OWN_VGA);
  assign blt_rvalid = tag_valid && (tag_owner == OWN_BLT);
  assign vga_rdata  = vga_rvalid ? fb_rdata : '0;
  assign blt_rdata  = blt_rvalid ? fb_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_rd      <= 1'b0;
      fb_addr    <= '0;
      starve_cnt <= '0;
    end else begin
      fb_rd <= any_gnt;
      if (vga_gnt) begin
        fb_addr <= vga_addr;
      end else if (blt_gnt) begin
        fb_addr <= blt_addr;
      end
      if (!blt_req || blt_gnt) begin
        starve_cnt <= '0;
      end else if (vga_gnt && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_RUN;
      drained <= 1'b0;
    end else begin
      case (state)
        ARB_RUN: begin
          if (!enable) begin
            state <= ARB_DRAIN;
          end
        end
        ARB_DRAIN: begin
          if (enable) begin
            state <= ARB_RUN;
          end else if (pipe_empty) begin
            state   <= ARB_HALT;
            drained <= 1'b1;
          end
        end
        ARB_HALT: begin
          if (enable) begin
            state   <= ARB_RUN;
            drained <= 1'b0;
          end
        end
        default: begin
          state   <= ARB_RUN;
          drained <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Directed bench for fb_read_arbiter: main instance at RD_LAT=2 with a byte
// model on the port, plus RD_LAT=1 and RD_LAT=4 instances for latency checks.
module tb_fb_read_arbiter;

  localparam int AW = 21;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          vga_req, blt_req;
  logic [AW-1:0] vga_addr, blt_addr;

  logic          drained, vga_gnt, blt_gnt, vga_rvalid, blt_rvalid, fb_rd;
  logic [DW-1:0] vga_rdata, blt_rdata, fb_rdata;
  logic [AW-1:0] fb_addr;
  logic [3:0]    starve_cnt;

  logic          l1_drained, l1_vga_gnt, l1_blt_gnt, l1_vga_rvalid, l1_blt_rvalid, l1_fb_rd;
  logic [DW-1:0] l1_vga_rdata, l1_blt_rdata;
  logic [AW-1:0] l1_fb_addr;
  logic [3:0]    l1_starve_cnt;

  logic          l4_drained, l4_vga_gnt, l4_blt_gnt, l4_vga_rvalid, l4_blt_rvalid, l4_fb_rd;
  logic [DW-1:0] l4_vga_rdata, l4_blt_rdata;
  logic [AW-1:0] l4_fb_addr;
  logic [3:0]    l4_starve_cnt;

  logic [AW-1:0] addr_d1, addr_d2;
  logic [DW-1:0] const_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Port model for the RD_LAT=2 instance: data is a fixed function of the
  // address that was on fb_addr two cycles earlier.
  function automatic logic [DW-1:0] model_byte(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h83;
  endfunction

  always @(posedge clk) begin
    addr_d1 <= fb_addr;
    addr_d2 <= addr_d1;
  end

  assign fb_rdata    = model_byte(addr_d2);
  assign const_rdata = 8'h3C;

  fb_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .drained(drained),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .blt_req(blt_req), .blt_addr(blt_addr), .blt_gnt(blt_gnt),
    .blt_rvalid(blt_rvalid), .blt_rdata(blt_rdata),
    .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_rdata(fb_rdata), .starve_cnt(starve_cnt)
  );

  fb_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(8)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .drained(l1_drained),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(l1_vga_gnt),
    .vga_rvalid(l1_vga_rvalid), .vga_rdata(l1_vga_rdata),
    .blt_req(blt_req), .blt_addr(blt_addr), .blt_gnt(l1_blt_gnt),
    .blt_rvalid(l1_blt_rvalid), .blt_rdata(l1_blt_rdata),
    .fb_addr(l1_fb_addr), .fb_rd(l1_fb_rd), .fb_rdata(const_rdata), .starve_cnt(l1_starve_cnt)
  );

  fb_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(4), .STARVE_MAX(8)) dut_l4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .drained(l4_drained),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(l4_vga_gnt),
    .vga_rvalid(l4_vga_rvalid), .vga_rdata(l4_vga_rdata),
    .blt_req(blt_req), .blt_addr(blt_addr), .blt_gnt(l4_blt_gnt),
    .blt_rvalid(l4_blt_rvalid), .blt_rdata(l4_blt_rdata),
    .fb_addr(l4_fb_addr), .fb_rd(l4_fb_rd), .fb_rdata(const_rdata), .starve_cnt(l4_starve_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic          exp_blt, exp_vv, exp_bv;
    logic [DW-1:0] exp_vd, exp_bd;

    rst_n = 1'b0; enable = 1'b1;
    vga_req = 1'b1; blt_req = 1'b1; vga_addr = '0; blt_addr = '0;
    #2;
    // Reset state, with both requests high to show grants are held off
    chk("rst_fb_rd", fb_rd, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_starve", starve_cnt, 0);
    chk("rst_drained", drained, 0);
    chk("rst_vga_gnt", vga_gnt, 0);
    chk("rst_blt_gnt", blt_gnt, 0);
    chk("rst_vga_rvalid", vga_rvalid, 0);
    chk("rst_blt_rvalid", blt_rvalid, 0);
    vga_req = 1'b0; blt_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single VGA read and latency on all three builds
    vga_req = 1'b1; vga_addr = 21'h001234; #1;
    chk("t1_vga_gnt", vga_gnt, 1);
    chk("t1_blt_gnt", blt_gnt, 0);
    tick(); vga_req = 1'b0;
    chk("t1_fb_rd", fb_rd, 1);
    chk("t1_fb_addr", fb_addr, 21'h001234);
    chk("t1_vga_rvalid_early", vga_rvalid, 0);
    chk("t1_l1_rvalid_early", l1_vga_rvalid, 0);
    tick();
    chk("t1_fb_rd_idle", fb_rd, 0);
    chk("t1_fb_addr_hold", fb_addr, 21'h001234);
    chk("t1_vga_rvalid_k2", vga_rvalid, 0);
    chk("t1_l1_rvalid", l1_vga_rvalid, 1);
    chk("t1_l1_rdata", l1_vga_rdata, 8'h3C);
    tick();
    chk("t1_vga_rvalid", vga_rvalid, 1);
    chk("t1_vga_rdata", vga_rdata, 8'hA5);
    chk("t1_blt_rvalid", blt_rvalid, 0);
    chk("t1_blt_rdata", blt_rdata, 0);
    chk("t1_l1_rvalid_after", l1_vga_rvalid, 0);
    chk("t1_l4_rvalid_k3", l4_vga_rvalid, 0);
    tick();
    chk("t1_vga_rvalid_after", vga_rvalid, 0);
    chk("t1_l4_rvalid_k4", l4_vga_rvalid, 0);
    tick();
    chk("t1_l4_rvalid", l4_vga_rvalid, 1);
    chk("t1_l4_rdata", l4_vga_rdata, 8'h3C);
    tick();
    chk("t1_l4_rvalid_after", l4_vga_rvalid, 0);

    // Both requesting continuously: 8 VGA grants then one forced BLT grant
    vga_req = 1'b1; blt_req = 1'b1; vga_addr = 21'd100; blt_addr = 21'd200;
    for (int i = 0; i < 18; i++) begin
      #1;
      exp_blt = ((i % 9) == 8);
      exp_vv  = (i >= 3) && (((i - 3) % 9) != 8);
      exp_bv  = (i >= 3) && (((i - 3) % 9) == 8);
      exp_vd  = exp_vv ? 8'hE7 : 8'h00;
      exp_bd  = exp_bv ? 8'h4B : 8'h00;
      chk($sformatf("t2_vga_gnt_%0d", i), vga_gnt, !exp_blt);
      chk($sformatf("t2_blt_gnt_%0d", i), blt_gnt, exp_blt);
      chk($sformatf("t2_starve_%0d", i), starve_cnt, i % 9);
      if (i > 0) chk($sformatf("t2_fb_rd_%0d", i), fb_rd, 1);
      chk($sformatf("t2_vga_rvalid_%0d", i), vga_rvalid, exp_vv);
      chk($sformatf("t2_blt_rvalid_%0d", i), blt_rvalid, exp_bv);
      chk($sformatf("t2_vga_rdata_%0d", i), vga_rdata, exp_vd);
      chk($sformatf("t2_blt_rdata_%0d", i), blt_rdata, exp_bd);
      tick();
    end
    vga_req = 1'b0; blt_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t2_starve_clear", starve_cnt, 0);

    // Alternating owners return in grant order
    vga_req = 1'b1; vga_addr = 21'd10; #1;
    chk("t3_vga_gnt_a", vga_gnt, 1);
    tick();
    vga_req = 1'b0; blt_req = 1'b1; blt_addr = 21'd20; #1;
    chk("t3_blt_gnt", blt_gnt, 1);
    chk("t3_vga_gnt_none", vga_gnt, 0);
    tick();
    blt_req = 1'b0; vga_req = 1'b1; vga_addr = 21'd30; #1;
    chk("t3_vga_gnt_b", vga_gnt, 1);
    tick();
    vga_req = 1'b0; #1;
    chk("t3_rv1_vga", vga_rvalid, 1);
    chk("t3_rd1_vga", vga_rdata, 8'h89);
    chk("t3_rv1_blt", blt_rvalid, 0);
    tick();
    chk("t3_rv2_blt", blt_rvalid, 1);
    chk("t3_rd2_blt", blt_rdata, 8'h97);
    chk("t3_rv2_vga", vga_rvalid, 0);
    chk("t3_rd2_vga", vga_rdata, 0);
    tick();
    chk("t3_rv3_vga", vga_rvalid, 1);
    chk("t3_rd3_vga", vga_rdata, 8'h9D);
    tick();
    chk("t3_rv4_vga", vga_rvalid, 0);
    chk("t3_rv4_blt", blt_rvalid, 0);

    // Drain with three BLT reads in flight, then resume
    blt_req = 1'b1; blt_addr = 21'd40; #1;
    chk("t4_gnt0", blt_gnt, 1);
    tick();
    blt_addr = 21'd41; #1;
    chk("t4_gnt1", blt_gnt, 1);
    tick();
    blt_addr = 21'd42; #1;
    chk("t4_gnt2", blt_gnt, 1);
    tick();
    enable = 1'b0; #1;
    chk("t4_gnt_refused", blt_gnt, 0);
    chk("t4_rv0", blt_rvalid, 1);
    chk("t4_rd0", blt_rdata, 8'hAB);
    tick();
    chk("t4_gnt_drain", blt_gnt, 0);
    chk("t4_rv1", blt_rvalid, 1);
    chk("t4_rd1", blt_rdata, 8'hAA);
    chk("t4_drained_a", drained, 0);
    tick();
    chk("t4_rv2", blt_rvalid, 1);
    chk("t4_rd2", blt_rdata, 8'hA9);
    chk("t4_drained_b", drained, 0);
    tick();
    chk("t4_drained", drained, 1);
    chk("t4_rv_none", blt_rvalid, 0);
    chk("t4_gnt_halt", blt_gnt, 0);
    tick();
    enable = 1'b1; #1;
    chk("t4_gnt_halt_en", blt_gnt, 0);
    chk("t4_drained_still", drained, 1);
    tick();
    chk("t4_drained_fall", drained, 0);
    chk("t4_gnt_resume", blt_gnt, 1);
    tick();
    blt_req = 1'b0;
    chk("t4_fb_rd_resume", fb_rd, 1);
    tick(); tick(); tick();

    // Reset pulse with two reads in flight
    vga_req = 1'b1; blt_req = 1'b1; vga_addr = 21'd50; #1;
    chk("t5_gnt0", vga_gnt, 1);
    tick();
    vga_addr = 21'd51; #1;
    chk("t5_gnt1", vga_gnt, 1);
    chk("t5_starve_pre", starve_cnt, 1);
    tick();
    rst_n = 1'b0; vga_req = 1'b0; blt_req = 1'b0; #1;
    chk("t5_fb_rd_rst", fb_rd, 0);
    chk("t5_starve_rst", starve_cnt, 0);
    chk("t5_rv_rst", vga_rvalid, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t5_vga_rvalid_%0d", i), vga_rvalid, 0);
      chk($sformatf("t5_blt_rvalid_%0d", i), blt_rvalid, 0);
      tick();
    end
    vga_req = 1'b1; vga_addr = 21'd60; #1;
    chk("t5_run_gnt", vga_gnt, 1);
    chk("t5_drained", drained, 0);
    tick();
    vga_req = 1'b0;
    tick(); tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
